multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle datapath. It sequences Stage1 (PC register, instruction/data address mux, unified cache port) and the later stages by driving the shared 22-bit `control` word once per cycle. It decodes the fetched opcode and steps through fetch, decode, execute, memory and writeback states. It stalls on the cache handshake and enforces a bounded memory-wait timeout.

---
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle datapath: sequences fetch/decode/execute/
// memory/writeback by driving the 22-bit control word, with a bounded memory wait.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic [21:0] control,
  output logic [3:0]  state_out,
  output logic        instr_done,
  output logic        illegal_op,
  output logic        mem_timeout
);
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_SLTI = 6'h0A, OP_J = 6'h02;

  localparam int B_PCWC = 21, B_IRW = 20, B_M2R = 19, B_PCW = 18, B_IDAT = 17, B_MRD = 16,
                 B_MWR = 15, B_RW = 14, B_RDST = 13, B_ASA = 12, B_EXT = 3, B_BNE = 2;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_FUNCT = 4'd2, ALU_AND = 4'd3,
                         ALU_OR = 4'd4, ALU_SLT = 4'd5;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3, S_MEMWB = 4'd4,
    S_MEMWR = 4'd5, S_EXEC_R = 4'd6, S_RWB = 4'd7, S_EXEC_I = 4'd8, S_IWB = 4'd9,
    S_BRANCH = 4'd10, S_JUMP = 4'd11
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   wait_q;
  logic            timeout_q;
  logic [5:0]      op_q;
  logic            in_mem, tmo_now, legal_op;
  logic [21:0]     ctl_c;
  logic            done_c;

  always_comb begin
    case (opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ANDI, OP_ORI, OP_SLTI, OP_J: legal_op = 1'b1;
      default:                        legal_op = 1'b0;
    endcase
  end

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Timeout wins over a late mem_ready: once the count is reached the access is abandoned.
  assign tmo_now = in_mem && (wait_q == CW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      op_q      <= '0;
    end else begin
      wait_q <= '0;
      if (state_q == S_DECODE) op_q <= opcode;
      if (tmo_now) begin
        timeout_q <= 1'b1;
        state_q   <= S_FETCH;
      end else begin
        case (state_q)
          S_FETCH:  if (mem_ready) state_q <= S_DECODE; else wait_q <= wait_q + CW'(1);
          S_DECODE: begin
            case (opcode)
              OP_R:                               state_q <= S_EXEC_R;
              OP_LW, OP_SW:                       state_q <= S_MEMADR;
              OP_BEQ, OP_BNE:                     state_q <= S_BRANCH;
              OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_q <= S_EXEC_I;
              OP_J:                               state_q <= S_JUMP;
              default:                            state_q <= S_FETCH;
            endcase
          end
          S_MEMADR: state_q <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
          S_MEMRD:  if (mem_ready) state_q <= S_MEMWB; else wait_q <= wait_q + CW'(1);
          S_MEMWR:  if (mem_ready) state_q <= S_FETCH; else wait_q <= wait_q + CW'(1);
          S_EXEC_R: state_q <= S_RWB;
          S_EXEC_I: state_q <= S_IWB;
          default:  state_q <= S_FETCH;
        endcase
      end
    end
  end

  always_comb begin
    ctl_c  = '0;
    done_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctl_c[B_MRD]  = ~tmo_now;
        ctl_c[11:10]  = 2'b01;
        ctl_c[B_IRW]  = mem_ready & ~tmo_now;
        ctl_c[B_PCW]  = mem_ready & ~tmo_now;
      end
      S_DECODE: begin
        ctl_c[11:10] = 2'b11;
        ctl_c[B_EXT] = 1'b1;
      end
      S_MEMADR: begin
        ctl_c[B_ASA] = 1'b1; ctl_c[11:10] = 2'b10; ctl_c[B_EXT] = 1'b1;
      end
      S_MEMRD: begin
        ctl_c[B_IDAT] = 1'b1; ctl_c[B_MRD] = ~tmo_now;
      end
      S_MEMWB: begin
        ctl_c[B_RW] = 1'b1; ctl_c[B_M2R] = 1'b1; done_c = 1'b1;
      end
      S_MEMWR: begin
        ctl_c[B_IDAT] = 1'b1; ctl_c[B_MWR] = ~tmo_now;
        done_c        = mem_ready & ~tmo_now;
      end
      S_EXEC_R: begin
        ctl_c[B_ASA] = 1'b1; ctl_c[7:4] = ALU_FUNCT;
      end
      S_RWB: begin
        ctl_c[B_RW] = 1'b1; ctl_c[B_RDST] = 1'b1; done_c = 1'b1;
      end
      S_EXEC_I: begin
        ctl_c[B_ASA] = 1'b1; ctl_c[11:10] = 2'b10;
        case (op_q)
          OP_ANDI: ctl_c[7:4] = ALU_AND;
          OP_ORI:  ctl_c[7:4] = ALU_OR;
          OP_SLTI: begin ctl_c[7:4] = ALU_SLT; ctl_c[B_EXT] = 1'b1; end
          default: begin ctl_c[7:4] = ALU_ADD; ctl_c[B_EXT] = 1'b1; end
        endcase
      end
      S_IWB: begin
        ctl_c[B_RW] = 1'b1; done_c = 1'b1;
      end
      S_BRANCH: begin
        ctl_c[B_PCWC] = 1'b1; ctl_c[B_ASA] = 1'b1; ctl_c[9:8] = 2'b01;
        ctl_c[7:4]    = ALU_SUB; ctl_c[B_BNE] = (op_q == OP_BNE); done_c = 1'b1;
      end
      S_JUMP: begin
        ctl_c[B_PCW] = 1'b1; ctl_c[9:8] = 2'b10; done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Everything is forced quiet while reset is held, so no strobe escapes mid-instruction.
  assign control     = reset ? '0 : ctl_c;
  assign state_out   = reset ? 4'd0 : state_q;
  assign instr_done  = ~reset & done_c;
  assign illegal_op  = ~reset & (state_q == S_DECODE) & ~legal_op;
  assign mem_timeout = ~reset & timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction phase scripts with
// randomized cache latency, checked cycle by cycle.
module tb_multicycle_ctrl;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset, mem_ready;
  logic [5:0]  opcode;
  logic [21:0] control;
  logic [3:0]  state_out;
  logic        instr_done, illegal_op, mem_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_to = 1'b0;

  multicycle_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .control(control), .state_out(state_out), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02};
  endfunction

  // Control word assembled field by field from the documented bit map.
  function automatic logic [21:0] ctl(input bit pcwc, input bit irw, input bit m2r, input bit pcw,
                                      input bit idat, input bit mrd, input bit mwr, input bit rw,
                                      input bit rdst, input bit asa, input int asb, input int pcs,
                                      input int alu, input bit ext, input bit bne);
    return {pcwc, irw, m2r, pcw, idat, mrd, mwr, rw, rdst, asa, 2'(asb), 2'(pcs), 4'(alu), ext, bne, 2'b00};
  endfunction

  // Returns {control, instr_done, illegal_op} expected for a phase.
  function automatic logic [23:0] exp_out(input int st, input logic [5:0] op, input bit rdy, input bit tmo);
    logic [21:0] c;
    bit d, il;
    int alu;
    bit ext;
    c = '0; d = 1'b0; il = 1'b0; alu = 0; ext = 1'b1;
    case (st)
      0:  c = ctl(0, rdy && !tmo, 0, rdy && !tmo, 0, !tmo, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      1:  begin c = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0); il = !legal(op); end
      2:  c = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0);
      3:  c = ctl(0, 0, 0, 0, 1, !tmo, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      4:  begin c = ctl(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); d = 1'b1; end
      5:  begin c = ctl(0, 0, 0, 0, 1, 0, !tmo, 0, 0, 0, 0, 0, 0, 0, 0); d = rdy && !tmo; end
      6:  c = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0);
      7:  begin c = ctl(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0); d = 1'b1; end
      8:  begin
        case (op)
          6'h0C:   begin alu = 3; ext = 1'b0; end
          6'h0D:   begin alu = 4; ext = 1'b0; end
          6'h0A:   begin alu = 5; ext = 1'b1; end
          default: begin alu = 0; ext = 1'b1; end
        endcase
        c = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, alu, ext, 0);
      end
      9:  begin c = ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); d = 1'b1; end
      10: begin c = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, op == 6'h05); d = 1'b1; end
      11: begin c = ctl(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0); d = 1'b1; end
      default: c = '0;
    endcase
    return {c, d, il};
  endfunction

  // Drives one instruction: fw / mw = mem_ready-low cycles before the cache
  // answers in FETCH / the data access. Each cycle is compared against the script.
  task automatic run_instr(input string tag, input logic [5:0] op, input int fw, input int mw);
    int ph[$];
    int k;
    bit rdy, tmo, memph, aborted;
    logic [23:0] eo;
    logic [28:0] want, got;
    ph.push_back(0); ph.push_back(1);
    case (op)
      6'h00:                      begin ph.push_back(6); ph.push_back(7); end
      6'h23:                      begin ph.push_back(2); ph.push_back(3); ph.push_back(4); end
      6'h2B:                      begin ph.push_back(2); ph.push_back(5); end
      6'h04, 6'h05:               ph.push_back(10);
      6'h08, 6'h0C, 6'h0D, 6'h0A: begin ph.push_back(8); ph.push_back(9); end
      6'h02:                      ph.push_back(11);
      default: ;
    endcase
    aborted = 1'b0;
    for (int i = 0; i < ph.size() && !aborted; i++) begin
      memph = (ph[i] == 0) || (ph[i] == 3) || (ph[i] == 5);
      k = 0;
      forever begin
        @(negedge clk);
        if (i == 0 && k == 0) opcode = op;
        rdy = memph ? (k >= ((ph[i] == 0) ? fw : mw)) : ($urandom_range(0, 1) == 1);
        mem_ready = rdy;
        tmo = memph && (k == MW);
        #1;
        eo   = exp_out(ph[i], op, rdy, tmo);
        want = {4'(ph[i]), eo, exp_to};
        got  = {state_out, control, instr_done, illegal_op, mem_timeout};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL %s op=%h phase=%0d wait=%0d: got st/ctl/done/ill/to=%h want %h",
                   tag, op, ph[i], k, got, want);
        end
        if (tmo) begin exp_to = 1'b1; aborted = 1'b1; break; end
        if (!memph || rdy) break;
        k++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({state_out, control, instr_done, illegal_op, mem_timeout} !== 29'd0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got %h want 0", i,
                 {state_out, control, instr_done, illegal_op, mem_timeout});
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    exp_to = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (state_out !== 4'd0 || control !== 22'h150400) begin
      n_bad++;
      $display("FAIL reset_first_fetch: got st=%0d ctl=%h want st=0 ctl=150400", state_out, control);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (state_out !== 4'd1 || illegal_op !== 1'b1 || control !== 22'h000C08) begin
      n_bad++;
      $display("FAIL reset_then_illegal: got st=%0d ill=%b ctl=%h want st=1 ill=1 ctl=000c08",
               state_out, illegal_op, control);
    end
  endtask

  task automatic test_lw();        run_instr("lw", 6'h23, 0, 0); endtask
  task automatic test_sw_wait();   run_instr("sw_wait3", 6'h2B, 0, 3); endtask
  task automatic test_branch();    run_instr("beq", 6'h04, 0, 0); run_instr("bne", 6'h05, 0, 0); endtask

  task automatic test_illegal();
    logic [5:0] op;
    run_instr("illegal_3f", 6'h3F, 0, 0);
    for (int i = 0; i < 6; i++) begin
      do op = 6'($urandom); while (legal(op));
      run_instr("illegal_rand", op, $urandom_range(0, 2), 0);
    end
  endtask

  task automatic test_exec_types();
    run_instr("rtype", 6'h00, 1, 0);
    run_instr("addi", 6'h08, 0, 0);
    run_instr("andi", 6'h0C, 2, 0);
    run_instr("ori", 6'h0D, 0, 0);
    run_instr("slti", 6'h0A, 1, 0);
    run_instr("jump", 6'h02, 0, 0);
    run_instr("lw_wait", 6'h23, 2, 3);
  endtask

  task automatic test_timeout();
    run_instr("timeout_fetch", 6'h00, 6, 0);
    run_instr("timeout_again", 6'h08, 6, 0);
    run_instr("timeout_lw", 6'h23, 0, 6);
    run_instr("timeout_sw", 6'h2B, 0, 6);
    run_instr("after_timeout", 6'h08, 0, 0);
  endtask

  task automatic test_reset_mid();
    opcode = 6'h23;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = (i == 0);
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    n_cmp++;
    if ({state_out, control, instr_done, illegal_op, mem_timeout} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_mid_memrd: got %h want 0",
               {state_out, control, instr_done, illegal_op, mem_timeout});
    end
    @(posedge clk); #1 reset = 1'b0;
    exp_to = 1'b0;
    run_instr("after_reset_mid", 6'h2B, 0, 1);
  endtask

  task automatic test_random();
    logic [5:0] legal_ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02};
    logic [5:0] op;
    int fw, mw;
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 9)] : 6'($urandom);
      fw = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
      run_instr("random", op, fw, mw);
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h3F;
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch();
    test_illegal();
    test_exec_types();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
